// File: rtl/sum_acc_pkg.sv
// Shared constants and helpers for the sum accumulation stage.
package sum_acc_pkg;

   localparam int DATA_W_DEF    = 8;
   localparam int ACC_W_DEF     = 16;
   localparam int BLOCK_LEN_DEF = 4;

   // Beat counter width; a one-beat block still needs a one-bit counter.
   function automatic int cnt_width(input int block_len);
      return (block_len <= 1) ? 1 : $clog2(block_len);
   endfunction

   localparam int CNT_W = cnt_width(BLOCK_LEN_DEF);

   // The output register is either empty or holding one completed block.
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/sum_accumulate_stage_if.sv
// Beat input stream and block-result output stream of the accumulate stage.
interface sum_accumulate_stage_if
   import sum_acc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic              out_ovf;

   // Producer of beats and consumer of results.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_acc, out_ovf
   );

   // The accumulate stage itself.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_acc, out_ovf
   );

endinterface

// File: rtl/sat_add_unsigned.sv
// Unsigned accumulator + beat adder with optional saturation on carry-out.
module sat_add_unsigned #(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [DATA_W-1:0] data,
   output logic [ACC_W-1:0]  result,
   output logic              overflow
);

   logic [ACC_W:0] sum;

   // One extra bit holds the carry that signals overflow.
   assign sum      = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, data};
   assign overflow = sum[ACC_W];
   assign result   = (overflow && SATURATE) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

endmodule

// File: rtl/sum_accumulate_stage.sv
// Accumulates BLOCK_LEN accepted sums and presents each block total through a
// single-entry valid/ready output register.
module sum_accumulate_stage
   import sum_acc_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int BLOCK_LEN = BLOCK_LEN_DEF,
   parameter bit SATURATE  = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  clear,
   sum_accumulate_stage_if.slave bus
);

   localparam int                CNT_BITS = cnt_width(BLOCK_LEN);
   localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(BLOCK_LEN - 1);

   out_state_e          state_q;
   out_state_e          state_d;
   logic [ACC_W-1:0]    acc_q;
   logic [CNT_BITS-1:0] cnt_q;
   logic                ovf_q;
   logic [ACC_W-1:0]    out_acc_q;
   logic                out_ovf_q;

   logic [ACC_W-1:0]    acc_n;
   logic                add_ovf;
   logic                ovf_n;
   logic                in_ready;
   logic                accept;
   logic                last_beat;

   sat_add_unsigned #(
      .DATA_W  (DATA_W),
      .ACC_W   (ACC_W),
      .SATURATE(SATURATE)
   ) u_add (
      .acc     (acc_q),
      .data    (bus.in_data),
      .result  (acc_n),
      .overflow(add_ovf)
   );

   // The output slot frees up in the same cycle it is popped, so out_ready
   // feeds in_ready directly; reset_n keeps the stage closed while in reset.
   assign in_ready  = reset_n & enable & ~clear & ((state_q == OUT_EMPTY) | bus.out_ready);
   assign accept    = bus.in_valid & in_ready;
   assign last_beat = accept & (cnt_q == LAST_CNT);
   assign ovf_n     = ovf_q | add_ovf;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == OUT_FULL);
   assign bus.out_acc   = out_acc_q;
   assign bus.out_ovf   = out_ovf_q;

   // Output occupancy state register.
   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (!reset_n) state_q <= OUT_EMPTY;
      else          state_q <= state_d;
   end

   // Output occupancy next state: fill on a block's last beat, drain on pop.
   always_comb begin
      // NOTE: default first so no path through this block leaves state_d
      // unassigned, which would infer a latch.
      state_d = state_q;
      case (state_q)
         OUT_EMPTY: if (last_beat) state_d = OUT_FULL;
         OUT_FULL:  if (!last_beat && bus.out_ready) state_d = OUT_EMPTY;
         default:   state_d = OUT_EMPTY;
      endcase
   end

   // Partial-block accumulator, beat counter, overflow flag and result register.
   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: every register here, including the held result, is reset so a
      // reset discards both the partial block and any unread total.
      if (!reset_n) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         out_acc_q <= '0;
         out_ovf_q <= 1'b0;
      end else if (clear) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (accept) begin
         if (last_beat) begin
            out_acc_q <= acc_n;
            out_ovf_q <= ovf_n;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
         end else begin
            acc_q <= acc_n;
            cnt_q <= cnt_q + 1'b1;
            ovf_q <= ovf_n;
         end
      end
   end

endmodule

// File: tb/tb_sum_accumulate_stage.sv
// Self-checking bench for sum_accumulate_stage: four configurations, an
// arithmetic reference model and per-instance expected-result queues.
module tb_sum_accumulate_stage;
   import sum_acc_pkg::*;

   // Instance index: 0 defaults, 1 ACC_W=9 saturating, 2 ACC_W=9 wrapping,
   // 3 BLOCK_LEN=1.
   localparam int ACC_W_T [4] = '{16, 9, 9, 16};
   localparam int SAT_T   [4] = '{1, 1, 0, 1};
   localparam int BLK_T   [4] = '{4, 4, 4, 1};

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic enable  = 1'b0;
   logic clear   = 1'b0;

   always #5 clock = ~clock;

   logic        in_valid_v  [4];
   logic [7:0]  in_data_v   [4];
   logic        out_ready_v [4];
   logic        in_ready_w  [4];
   logic        out_valid_w [4];
   logic [15:0] out_acc_w   [4];
   logic        out_ovf_w   [4];

   int checks   = 0;
   int failures = 0;

   int m_acc [4];
   int m_cnt [4];
   int m_ovf [4];

   logic [16:0] exp_q0[$];
   logic [16:0] exp_q1[$];
   logic [16:0] exp_q2[$];
   logic [16:0] exp_q3[$];

   sum_accumulate_stage_if #(.DATA_W(8), .ACC_W(16)) if_def ();
   sum_accumulate_stage_if #(.DATA_W(8), .ACC_W(9))  if_sat ();
   sum_accumulate_stage_if #(.DATA_W(8), .ACC_W(9))  if_wrap ();
   sum_accumulate_stage_if #(.DATA_W(8), .ACC_W(16)) if_one ();

   assign if_def.in_valid  = in_valid_v[0];
   assign if_def.in_data   = in_data_v[0];
   assign if_def.out_ready = out_ready_v[0];
   assign in_ready_w[0]    = if_def.in_ready;
   assign out_valid_w[0]   = if_def.out_valid;
   assign out_acc_w[0]     = if_def.out_acc;
   assign out_ovf_w[0]     = if_def.out_ovf;

   assign if_sat.in_valid  = in_valid_v[1];
   assign if_sat.in_data   = in_data_v[1];
   assign if_sat.out_ready = out_ready_v[1];
   assign in_ready_w[1]    = if_sat.in_ready;
   assign out_valid_w[1]   = if_sat.out_valid;
   assign out_acc_w[1]     = {7'b0, if_sat.out_acc};
   assign out_ovf_w[1]     = if_sat.out_ovf;

   assign if_wrap.in_valid  = in_valid_v[2];
   assign if_wrap.in_data   = in_data_v[2];
   assign if_wrap.out_ready = out_ready_v[2];
   assign in_ready_w[2]     = if_wrap.in_ready;
   assign out_valid_w[2]    = if_wrap.out_valid;
   assign out_acc_w[2]      = {7'b0, if_wrap.out_acc};
   assign out_ovf_w[2]      = if_wrap.out_ovf;

   assign if_one.in_valid  = in_valid_v[3];
   assign if_one.in_data   = in_data_v[3];
   assign if_one.out_ready = out_ready_v[3];
   assign in_ready_w[3]    = if_one.in_ready;
   assign out_valid_w[3]   = if_one.out_valid;
   assign out_acc_w[3]     = if_one.out_acc;
   assign out_ovf_w[3]     = if_one.out_ovf;

   sum_accumulate_stage #(.DATA_W(8), .ACC_W(16), .BLOCK_LEN(4), .SATURATE(1'b1)) u_def (
      .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .bus(if_def)
   );
   sum_accumulate_stage #(.DATA_W(8), .ACC_W(9), .BLOCK_LEN(4), .SATURATE(1'b1)) u_sat (
      .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .bus(if_sat)
   );
   sum_accumulate_stage #(.DATA_W(8), .ACC_W(9), .BLOCK_LEN(4), .SATURATE(1'b0)) u_wrap (
      .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .bus(if_wrap)
   );
   sum_accumulate_stage #(.DATA_W(8), .ACC_W(16), .BLOCK_LEN(1), .SATURATE(1'b1)) u_one (
      .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .bus(if_one)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_exp(input int k, input logic [16:0] e);
      case (k)
         0:       exp_q0.push_back(e);
         1:       exp_q1.push_back(e);
         2:       exp_q2.push_back(e);
         default: exp_q3.push_back(e);
      endcase
   endtask

   task automatic pop_check(input int k);
      logic [16:0] e;
      int          n;
      case (k)
         0:       n = exp_q0.size();
         1:       n = exp_q1.size();
         2:       n = exp_q2.size();
         default: n = exp_q3.size();
      endcase
      check($sformatf("sb%0d_pending", k), 32'(n != 0), 32'd1);
      if (n != 0) begin
         case (k)
            0:       e = exp_q0.pop_front();
            1:       e = exp_q1.pop_front();
            2:       e = exp_q2.pop_front();
            default: e = exp_q3.pop_front();
         endcase
         check($sformatf("sb%0d_acc", k), 32'(out_acc_w[k]), 32'(e[15:0]));
         check($sformatf("sb%0d_ovf", k), 32'(out_ovf_w[k]), 32'(e[16]));
      end
   endtask

   // Reference arithmetic for one accepted beat.
   task automatic model_beat(input int k, input int d);
      int sum;
      int mx;
      logic [16:0] e;
      sum = m_acc[k] + d;
      mx  = (1 << ACC_W_T[k]) - 1;
      if (sum > mx) begin
         m_ovf[k] = 1;
         sum      = (SAT_T[k] != 0) ? mx : sum - (mx + 1);
      end
      m_acc[k] = sum;
      if (m_cnt[k] == BLK_T[k] - 1) begin
         e = {m_ovf[k][0], m_acc[k][15:0]};
         push_exp(k, e);
         m_acc[k] = 0;
         m_cnt[k] = 0;
         m_ovf[k] = 0;
      end else begin
         m_cnt[k]++;
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 4; k++) begin
         m_acc[k] = 0;
         m_cnt[k] = 0;
         m_ovf[k] = 0;
      end
   endtask

   task automatic model_reset();
      model_clear();
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
      exp_q3.delete();
   endtask

   // Present a beat and hold it until accepted (bounded).
   task automatic send(input int k, input logic [7:0] d);
      logic rdy;
      rdy = 1'b0;
      in_valid_v[k] = 1'b1;
      in_data_v[k]  = d;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         rdy = in_ready_w[k];
         @(posedge clock);
         #1;
         if (rdy) break;
      end
      check($sformatf("accept%0d", k), 32'(rdy), 32'd1);
      if (rdy) model_beat(k, int'(d));
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Result consumer: every pop is compared against the oldest expected total.
   always @(negedge clock) begin
      if (reset_n) begin
         for (int k = 0; k < 4; k++) begin
            if (out_valid_w[k] && out_ready_v[k]) pop_check(k);
         end
      end
   end

   initial begin
      for (int k = 0; k < 4; k++) begin
         in_valid_v[k]  = 1'b0;
         in_data_v[k]   = 8'd0;
         out_ready_v[k] = 1'b1;
      end
      model_reset();
      enable = 1'b1;

      // Reset state, including in_ready held low during reset.
      #2;
      check("rst_in_ready", 32'(in_ready_w[0]), 32'd0);
      check("rst_out_valid", 32'(out_valid_w[0]), 32'd0);
      check("rst_out_acc", 32'(out_acc_w[0]), 32'd0);
      check("rst_out_ovf", 32'(out_ovf_w[0]), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // 1: basic block with one-cycle result latency.
      send(0, 8'd10);
      send(0, 8'd20);
      send(0, 8'd30);
      send(0, 8'd40);
      in_valid_v[0] = 1'b0;
      check("t1_valid", 32'(out_valid_w[0]), 32'd1);
      check("t1_acc", 32'(out_acc_w[0]), 32'd100);
      cycles(1);
      check("t1_valid_drop", 32'(out_valid_w[0]), 32'd0);

      // 2: overflow, saturating then wrapping.
      for (int i = 0; i < 4; i++) send(1, 8'd255);
      in_valid_v[1] = 1'b0;
      for (int i = 0; i < 4; i++) send(2, 8'd255);
      in_valid_v[2] = 1'b0;
      cycles(2);

      // 3: backpressure holds the result and closes the input.
      out_ready_v[0] = 1'b0;
      for (int i = 0; i < 4; i++) send(0, 8'd1);
      in_data_v[0] = 8'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("t3_in_ready", 32'(in_ready_w[0]), 32'd0);
         check("t3_held_acc", 32'(out_acc_w[0]), 32'd4);
         check("t3_held_valid", 32'(out_valid_w[0]), 32'd1);
         @(posedge clock);
         #1;
      end
      out_ready_v[0] = 1'b1;
      send(0, 8'd1);
      for (int i = 0; i < 3; i++) send(0, 8'd1);
      in_valid_v[0] = 1'b0;
      cycles(2);

      // 4: clear mid-block discards the partial block and the clear-cycle beat.
      send(0, 8'd5);
      send(0, 8'd5);
      in_data_v[0] = 8'd9;
      clear = 1'b1;
      @(negedge clock);
      check("t4_clear_in_ready", 32'(in_ready_w[0]), 32'd0);
      @(posedge clock);
      #1;
      clear = 1'b0;
      model_clear();
      for (int i = 0; i < 4; i++) send(0, 8'd1);
      in_valid_v[0] = 1'b0;
      cycles(2);

      // Reset with a partial block pending.
      send(0, 8'd9);
      send(0, 8'd9);
      in_valid_v[0] = 1'b0;
      #3;
      reset_n = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) send(0, 8'd3);
      in_valid_v[0] = 1'b0;
      cycles(2);

      // 5: asynchronous reset while a result is held.
      out_ready_v[0] = 1'b0;
      for (int i = 0; i < 4; i++) send(0, 8'd5);
      in_valid_v[0] = 1'b0;
      check("t5_held", 32'(out_valid_w[0]), 32'd1);
      #3;
      reset_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(out_valid_w[0]), 32'd0);
      check("t5_rst_acc", 32'(out_acc_w[0]), 32'd0);
      check("t5_rst_ovf", 32'(out_ovf_w[0]), 32'd0);
      model_reset();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      out_ready_v[0] = 1'b1;
      for (int i = 0; i < 4; i++) send(0, 8'd2);
      in_valid_v[0] = 1'b0;
      cycles(2);

      // 6: one-beat blocks at full rate, with an enable gap mid-stream.
      send(3, 8'd7);
      check("t6_valid_a", 32'(out_valid_w[3]), 32'd1);
      check("t6_acc_a", 32'(out_acc_w[3]), 32'd7);
      send(3, 8'd8);
      check("t6_valid_b", 32'(out_valid_w[3]), 32'd1);
      check("t6_acc_b", 32'(out_acc_w[3]), 32'd8);
      in_data_v[3] = 8'd9;
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("t6_disabled_ready", 32'(in_ready_w[3]), 32'd0);
         @(posedge clock);
         #1;
      end
      enable = 1'b1;
      send(3, 8'd9);
      check("t6_acc_c", 32'(out_acc_w[3]), 32'd9);
      send(3, 8'd10);
      in_valid_v[3] = 1'b0;
      cycles(3);

      // Every expected result must have been delivered.
      check("sb_drain", 32'(exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
